wb_trace_uart_tx: RTL and testbench

WB_TRACE_UART_TX -- requirements
Module: wb_trace_uart_tx

---
 rtl/wb_trace_uart_tx_pkg.sv | 31 +++
 rtl/wb_trace_uart_tx_trace_fifo.sv | 47 ++++
 rtl/wb_trace_uart_tx.sv | 150 +++++++++++++++
 tb/tb_wb_trace_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_uart_tx_pkg.sv
// Shared definitions for the writeback trace UART transmitter.
// Holds the serializer state type, record geometry and byte selector.
package wb_trace_uart_tx_pkg;

    localparam int REC_W         = 37;
    localparam int BYTES_PER_REC = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    // Byte 0 carries the destination, bytes 1..4 the value MSB first.
    function automatic logic [7:0] rec_byte(
        input logic [REC_W-1:0] rec,
        input logic [2:0]       idx
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = {3'b000, rec[36:32]};
            3'd1:    b = rec[31:24];
            3'd2:    b = rec[23:16];
            3'd3:    b = rec[15:8];
            default: b = rec[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/wb_trace_uart_tx_trace_fifo.sv
// Synchronous FIFO for trace records with extra-bit full/empty pointers.
// Ports: i_clk, i_rst_n, i_push/i_data, i_pop/o_data (head), o_full, o_empty.
module trace_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wptr;
    logic [AW:0]  r_rptr;
    logic         w_do_push;
    logic         w_do_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || i_pop);
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/wb_trace_uart_tx.sv
// Writeback trace: buffers {dest, value} records and sends them 8N1 on tx.
// Ports: clk, rst (async low), wb_en/wb_dest/wb_value in; tx, busy, overflow out.
module wb_trace_uart_tx
    import wb_trace_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_value,
    output logic        tx,
    output logic        busy,
    output logic        overflow
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    BYTE_LAST = 3'(BYTES_PER_REC - 1);

    logic             r_push;
    logic [REC_W-1:0] r_rec;
    logic             r_ovf;
    tx_state_t        r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_bit;
    logic [2:0]       r_byte;
    logic [REC_W-1:0] r_shadow;
    logic [7:0]       r_sh;
    logic             r_tx;

    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [REC_W-1:0] w_head;
    logic             w_bit_end;
    logic             w_rec_end;

    assign w_bit_end = (r_cnt == BIT_LAST);
    assign w_rec_end = (r_state == ST_STOP) && w_bit_end &&
                       (r_byte == BYTE_LAST);
    // Head is taken when idle or right at the end of the previous record.
    assign w_pop     = !w_empty && ((r_state == ST_IDLE) || w_rec_end);

    assign tx       = r_tx;
    assign busy     = (r_state != ST_IDLE) || !w_empty;
    assign overflow = r_ovf;

    // Input capture stage: $0 writes never become records.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_push <= 1'b0;
            r_rec  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_push <= wb_en && (wb_dest != 5'd0);
            r_rec  <= {wb_dest, wb_value};
            if (r_push && w_full && !w_pop) r_ovf <= 1'b1;
        end
    end

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_push  (r_push),
        .i_data  (r_rec),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_byte   <= '0;
            r_shadow <= '0;
            r_sh     <= '0;
            r_tx     <= 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_tx  <= 1'b1;
                    r_cnt <= '0;
                    if (!w_empty) begin
                        r_shadow <= w_head;
                        r_byte   <= '0;
                        r_sh     <= rec_byte(w_head, 3'd0);
                        r_tx     <= 1'b0;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_sh[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                            r_sh  <= {1'b0, r_sh[7:1]};
                            r_tx  <= r_sh[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_byte != BYTE_LAST) begin
                            r_byte  <= r_byte + 3'd1;
                            r_sh    <= rec_byte(r_shadow, r_byte + 3'd1);
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else if (!w_empty) begin
                            r_shadow <= w_head;
                            r_byte   <= '0;
                            r_sh     <= rec_byte(w_head, 3'd0);
                            r_tx     <= 1'b0;
                            r_state  <= ST_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_trace_uart_tx.sv
// Self-checking bench for wb_trace_uart_tx.
// Decodes the serial line into a byte queue and compares against expected records.
module tb_wb_trace_uart_tx;

    localparam int CPB  = 4;
    localparam int CPB2 = 434;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_value = '0;
    logic        tx, busy, overflow;

    logic        wb_en2 = 1'b0;
    logic [4:0]  wb_dest2 = '0;
    logic [31:0] wb_value2 = '0;
    logic        tx2, busy2, overflow2;

    int checks = 0;
    int errors = 0;
    int epoch  = 0;

    logic [8:0] rx_q [$];
    logic [8:0] exp_q [$];

    int         mon_ep;
    logic       mon_ok;
    logic [7:0] mon_b;

    always #5 clk = ~clk;

    wb_trace_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en),
        .wb_dest  (wb_dest),
        .wb_value (wb_value),
        .tx       (tx),
        .busy     (busy),
        .overflow (overflow)
    );

    wb_trace_uart_tx dut2 (
        .clk      (clk),
        .rst      (rst),
        .wb_en    (wb_en2),
        .wb_dest  (wb_dest2),
        .wb_value (wb_value2),
        .tx       (tx2),
        .busy     (busy2),
        .overflow (overflow2)
    );

    // UART receiver: bytes started before the latest reset are discarded.
    always begin
        @(negedge clk);
        if (rst === 1'b1 && tx === 1'b0) begin
            mon_ep = epoch;
            mon_ok = 1'b1;
            repeat (CPB / 2) @(negedge clk);
            if (tx !== 1'b0) mon_ok = 1'b0;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                mon_b[k] = tx;
            end
            repeat (CPB) @(negedge clk);
            if (tx !== 1'b1) mon_ok = 1'b0;
            if (mon_ep == epoch) rx_q.push_back({~mon_ok, mon_b});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [4:0] d,
                                           input logic [31:0] v,
                                           input int j);
        logic [7:0] b;
        if (j == 0) b = {3'b000, d};
        else        b = 8'(v >> (8 * (4 - j)));
        return b;
    endfunction

    task automatic exp_rec(input logic [4:0] d, input logic [31:0] v);
        for (int j = 0; j < 5; j++) exp_q.push_back({1'b0, byte_of(d, v, j)});
    endtask

    task automatic check_bytes(input string tag, input int n);
        int t;
        logic [8:0] o;
        logic [8:0] e;
        t = 0;
        while (rx_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_count"}, 32'(rx_q.size() >= n), 32'd1);
        for (int i = 0; i < n && rx_q.size() > 0; i++) begin
            o = rx_q.pop_front();
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1ff;
            chk($sformatf("%s_b%0d", tag, i), 32'(o), 32'(e));
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    task automatic do_reset();
        epoch++;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int   bad;
        int   t;
        logic exp_bits [50];
        logic ok;
        logic [7:0] b;

        // Reset state
        #23;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single record, latency and total length
        exp_rec(5'd5, 32'hDEADBEEF);
        wb_en = 1'b1; wb_dest = 5'd5; wb_value = 32'hDEADBEEF;
        @(posedge clk); #1;
        wb_en = 1'b0;
        @(posedge clk); #1;
        chk("start_not_early", 32'(tx), 32'd1);
        @(posedge clk); #1;
        chk("start_edge", 32'(tx), 32'd0);
        repeat (199) @(posedge clk);
        #1;
        chk("busy_last_cycle", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("busy_done", 32'(busy), 32'd0);
        chk("tx_idle_done", 32'(tx), 32'd1);
        check_bytes("rec_deadbeef", 5);

        // $0 writes are ignored
        wb_en = 1'b1; wb_dest = 5'd0; wb_value = 32'h12345678;
        @(posedge clk); #1;
        wb_en = 1'b0;
        bad = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("dest0_quiet", 32'(bad), 32'd0);
        chk("dest0_no_ovf", 32'(overflow), 32'd0);
        chk("dest0_no_rx", 32'(rx_q.size()), 32'd0);

        // Overflow: six pushes into a depth-4 FIFO
        for (int d = 1; d <= 6; d++) begin
            wb_en = 1'b1; wb_dest = 5'(d); wb_value = 32'hC0DE0000 | 32'(d);
            @(posedge clk); #1;
        end
        wb_en = 1'b0;
        chk("ovf_not_yet", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        chk("ovf_set", 32'(overflow), 32'd1);
        for (int d = 1; d <= 5; d++) exp_rec(5'(d), 32'hC0DE0000 | 32'(d));
        check_bytes("ovf_order", 25);
        wait_idle();
        chk("ovf_idle", 32'(busy), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("ovf_dropped", 32'(rx_q.size()), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Push into full FIFO in the same cycle as a pop
        for (int d = 1; d <= 5; d++) begin
            wb_en = 1'b1; wb_dest = 5'(d); wb_value = 32'hF00D0000 | 32'(d);
            @(posedge clk); #1;
        end
        wb_en = 1'b0;
        repeat (196) @(posedge clk);
        #1;
        wb_en = 1'b1; wb_dest = 5'd6; wb_value = 32'hF00D0006;
        @(posedge clk); #1;
        wb_en = 1'b0;
        @(posedge clk); #1;
        chk("fullpop_no_ovf", 32'(overflow), 32'd0);
        for (int d = 1; d <= 6; d++) exp_rec(5'(d), 32'hF00D0000 | 32'(d));
        check_bytes("fullpop_order", 30);
        wait_idle();
        chk("fullpop_ovf_end", 32'(overflow), 32'd0);
        do_reset();

        // Reset in the middle of a byte
        exp_rec(5'd3, 32'hA5C30F96);
        wb_en = 1'b1; wb_dest = 5'd3; wb_value = 32'hA5C30F96;
        @(posedge clk); #1;
        wb_en = 1'b0;
        repeat (143) @(posedge clk);
        #1;
        chk("pre_reset_bit4", 32'(tx), 32'd0);
        #2;
        epoch++;
        rst = 1'b0;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("midrst_idle_tx", 32'(tx), 32'd1);
        check_bytes("pre_reset_bytes", 3);
        exp_q.delete();
        chk("midrst_no_extra", 32'(rx_q.size()), 32'd0);
        exp_rec(5'd7, 32'h00000001);
        wb_en = 1'b1; wb_dest = 5'd7; wb_value = 32'h00000001;
        @(posedge clk); #1;
        wb_en = 1'b0;
        check_bytes("post_reset_rec", 5);
        wait_idle();
        chk("post_reset_idle", 32'(busy), 32'd0);

        // Default bit period: every bit exactly CPB2 cycles
        for (int j = 0; j < 5; j++) begin
            b = byte_of(5'h15, 32'h55AA33CC, j);
            exp_bits[j * 10] = 1'b0;
            for (int k = 0; k < 8; k++) exp_bits[j * 10 + 1 + k] = b[k];
            exp_bits[j * 10 + 9] = 1'b1;
        end
        wb_en2 = 1'b1; wb_dest2 = 5'h15; wb_value2 = 32'h55AA33CC;
        @(posedge clk); #1;
        wb_en2 = 1'b0;
        t = 0;
        @(negedge clk);
        while (tx2 !== 1'b0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("dflt_start_seen", 32'(tx2), 32'd0);
        for (int i = 0; i < 50; i++) begin
            ok = 1'b1;
            for (int j = 0; j < CPB2; j++) begin
                if (tx2 !== exp_bits[i]) ok = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("dflt_bit%0d", i), 32'(ok), 32'd1);
        end
        chk("dflt_tx_end", 32'(tx2), 32'd1);
        chk("dflt_busy_end", 32'(busy2), 32'd0);
        chk("dflt_ovf", 32'(overflow2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
